// File: rtl/alu_tx_sequencer.sv
// ALU result transmit sequencer: queues result words and
// streams each one to a UART as an optionally framed byte burst.
module alu_tx_sequencer #(
  parameter int          RESULT_W  = 16,
  parameter int          DEPTH     = 4,
  parameter int          FRAMED    = 1,
  parameter int          MSB_FIRST = 0,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [RESULT_W-1:0]     in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  input  logic                    tx_busy,
  output logic                    frame_active,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [7:0]              frames_sent
);
  localparam int NB    = RESULT_W / 8;
  localparam int N     = NB + 2 * FRAMED;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t state, state_nx;

  logic [RESULT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [RESULT_W-1:0] hold;
  logic [IDX_W-1:0]    idx;
  logic                push, pop, last;
  logic [7:0]          chk;
  logic [7:0]          fbytes [N];
  logic [7:0]          cur;

  assign in_ready = fifo_count < CNT_W'(DEPTH);
  assign push     = in_valid & in_ready;
  assign pop      = (state == IDLE) && (fifo_count != '0);
  assign last     = idx == IDX_W'(N - 1);

  always_ff @(posedge clock) begin
    if (reset && push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)
        fifo_count <= fifo_count + CNT_W'(1);
      else if (pop && !push)
        fifo_count <= fifo_count - CNT_W'(1);
    end
  end

  // The popped word is frozen here so FIFO traffic cannot disturb a frame.
  always_ff @(posedge clock) begin
    if (!reset)   hold <= '0;
    else if (pop) hold <= mem[rd_ptr];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      idx         <= '0;
      frames_sent <= '0;
    end else begin
      if (state == IDLE && pop) idx <= '0;
      if (state == WAIT_DONE && !tx_busy) begin
        if (last) begin
          idx         <= '0;
          frames_sent <= frames_sent + 8'd1;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

  always_comb begin
    chk = '0;
    for (int k = 0; k < NB; k++)
      chk = chk ^ hold[8*k +: 8];
  end

  always_comb begin
    for (int i = 0; i < N; i++)
      fbytes[i] = '0;
    for (int k = 0; k < NB; k++)
      fbytes[k + FRAMED] = (MSB_FIRST != 0)
        ? hold[8*(NB-1-k) +: 8]
        : hold[8*k +: 8];
    if (FRAMED != 0) begin
      fbytes[0]   = SYNC_BYTE;
      fbytes[N-1] = chk;
    end
    cur = '0;
    for (int i = 0; i < N; i++)
      if (idx == IDX_W'(i)) cur = fbytes[i];
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (pop) state_nx = START;
      START:     state_nx = WAIT_ACK;
      WAIT_ACK:  if (tx_busy) state_nx = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_nx = last ? IDLE : START;
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    tx_start     = 1'b0;
    tx_data      = 8'h00;
    frame_active = state != IDLE;
    if (state == START || state == WAIT_ACK) begin
      tx_start = 1'b1;
      tx_data  = cur;
    end
  end

endmodule

// File: tb/tb_alu_tx_sequencer.sv
// Directed bench for alu_tx_sequencer: three configurations,
// each driven against a simple UART busy model.
module tb_alu_tx_sequencer;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [15:0] in_data;
  logic        v0, v1, v2;
  logic        r0, r1, r2;
  logic        ts0, ts1, ts2;
  logic [7:0]  td0, td1, td2;
  logic        busy0, busy1, busy2;
  logic        fa0, fa1, fa2;
  logic [2:0]  fc0, fc1, fc2;
  logic [7:0]  fs0, fs1, fs2;

  int checks = 0;
  int errors = 0;

  int   cnt0 = 0, cnt1 = 0, cnt2 = 0;
  int   busy_len = 10;
  logic hold0 = 1'b0;
  logic noack0 = 1'b0;
  logic [7:0] q0[$], q1[$], q2[$];
  logic [7:0] exp_q[$];

  alu_tx_sequencer #(.RESULT_W(16), .DEPTH(4), .FRAMED(1), .MSB_FIRST(0))
  dut0 (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(v0),
    .in_ready(r0), .tx_start(ts0), .tx_data(td0), .tx_busy(busy0),
    .frame_active(fa0), .fifo_count(fc0), .frames_sent(fs0)
  );

  alu_tx_sequencer #(.RESULT_W(16), .DEPTH(4), .FRAMED(1), .MSB_FIRST(1))
  dut1 (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(v1),
    .in_ready(r1), .tx_start(ts1), .tx_data(td1), .tx_busy(busy1),
    .frame_active(fa1), .fifo_count(fc1), .frames_sent(fs1)
  );

  alu_tx_sequencer #(.RESULT_W(16), .DEPTH(4), .FRAMED(0), .MSB_FIRST(0))
  dut2 (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(v2),
    .in_ready(r2), .tx_start(ts2), .tx_data(td2), .tx_busy(busy2),
    .frame_active(fa2), .fifo_count(fc2), .frames_sent(fs2)
  );

  // UART models: accept a byte when idle, then stay busy busy_len cycles.
  assign busy0 = hold0 || (cnt0 != 0);
  assign busy1 = cnt1 != 0;
  assign busy2 = cnt2 != 0;

  always @(posedge clock) begin
    if (cnt0 != 0) cnt0 <= cnt0 - 1;
    else if (ts0 && !noack0) begin
      q0.push_back(td0);
      cnt0 <= busy_len;
    end
  end

  always @(posedge clock) begin
    if (cnt1 != 0) cnt1 <= cnt1 - 1;
    else if (ts1) begin
      q1.push_back(td1);
      cnt1 <= busy_len;
    end
  end

  always @(posedge clock) begin
    if (cnt2 != 0) cnt2 <= cnt2 - 1;
    else if (ts2) begin
      q2.push_back(td2);
      cnt2 <= busy_len;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_frame(input logic [15:0] w);
    exp_q.push_back(8'hA5);
    exp_q.push_back(w[7:0]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0] ^ w[15:8]);
  endtask

  task automatic cmp_log0(input string tag);
    chk({tag, "_len"}, 32'(q0.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk(tag, 32'(q0[i]), 32'(exp_q[i]));
  endtask

  task automatic wait_fs0(input logic [7:0] target, input int budget,
                          input string tag);
    int n = 0;
    while (fs0 !== target && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk(tag, 32'(fs0), 32'(target));
  endtask

  task automatic push_words0(input logic [15:0] w [4], input int n);
    for (int i = 0; i < n; i++) begin
      in_data = w[i];
      v0 = 1'b1;
      @(negedge clock);
    end
    v0 = 1'b0;
  endtask

  logic [15:0] w6 [6];
  logic [15:0] wa [4];
  logic        rdy;
  int          pushed;
  int          n;

  initial begin
    reset = 1'b0;
    v0 = 1'b1; v1 = 1'b0; v2 = 1'b0;
    in_data = 16'hBEEF;
    repeat (3) @(negedge clock);
    chk("rst_tx_start", 32'(ts0), 0);
    chk("rst_tx_data", 32'(td0), 0);
    chk("rst_frame_active", 32'(fa0), 0);
    chk("rst_fifo_count", 32'(fc0), 0);
    chk("rst_in_ready", 32'(r0), 1);
    chk("rst_frames_sent", 32'(fs0), 0);
    reset = 1'b1;
    v0 = 1'b0;
    @(negedge clock);
    chk("rst_no_push", 32'(fc0), 0);

    // Single word through all three configurations
    in_data = 16'h1234;
    v0 = 1'b1; v1 = 1'b1; v2 = 1'b1;
    @(negedge clock);
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    chk("t1_count_push", 32'(fc0), 1);
    chk("t1_idle_start", 32'(ts0), 0);
    @(negedge clock);
    chk("t1_start", 32'(ts0), 1);
    chk("t1_sync", 32'(td0), 'hA5);
    chk("t1_active", 32'(fa0), 1);
    chk("t1_count_pop", 32'(fc0), 0);
    chk("t1_msb_sync", 32'(td1), 'hA5);
    chk("t1_nf_first", 32'(td2), 'h34);
    @(negedge clock);
    chk("t1_ack_hold", 32'(ts0), 1);
    chk("t1_ack_data", 32'(td0), 'hA5);
    @(negedge clock);
    chk("t1_done_start", 32'(ts0), 0);
    chk("t1_done_data", 32'(td0), 0);
    wait_fs0(8'd1, 300, "t1_frames");
    chk("t1_inactive", 32'(fa0), 0);
    add_frame(16'h1234);
    cmp_log0("t1_bytes");
    n = 0;
    while ((fs1 !== 8'd1 || fs2 !== 8'd1) && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk("t1_msb_frames", 32'(fs1), 1);
    chk("t1_msb_len", 32'(q1.size()), 4);
    chk("t1_msb_b0", 32'(q1[0]), 'hA5);
    chk("t1_msb_b1", 32'(q1[1]), 'h12);
    chk("t1_msb_b2", 32'(q1[2]), 'h34);
    chk("t1_msb_b3", 32'(q1[3]), 'h26);
    chk("t1_nf_frames", 32'(fs2), 1);
    chk("t1_nf_len", 32'(q2.size()), 2);
    chk("t1_nf_b0", 32'(q2[0]), 'h34);
    chk("t1_nf_b1", 32'(q2[1]), 'h12);

    // Full FIFO with the UART stalled
    q0.delete();
    exp_q.delete();
    hold0 = 1'b1;
    w6 = '{16'hA1B2, 16'h0003, 16'hFF00, 16'h5A5A, 16'h8001, 16'hDEAD};
    for (int i = 0; i < 6; i++) begin
      in_data = w6[i];
      v0 = 1'b1;
      @(negedge clock);
    end
    v0 = 1'b0;
    chk("t2_full_count", 32'(fc0), 4);
    chk("t2_full_ready", 32'(r0), 0);
    chk("t2_active", 32'(fa0), 1);
    hold0 = 1'b0;
    wait_fs0(8'd6, 3000, "t2_frames");
    for (int i = 0; i < 5; i++) add_frame(w6[i]);
    cmp_log0("t2_bytes");
    chk("t2_empty", 32'(fc0), 0);

    // Simultaneous push and pop at count 2
    q0.delete();
    exp_q.delete();
    hold0 = 1'b1;
    wa = '{16'h1111, 16'h2345, 16'hC0DE, 16'h7E81};
    push_words0(wa, 3);
    chk("t3_count2", 32'(fc0), 2);
    hold0 = 1'b0;
    n = 0;
    while (!(fa0 == 1'b0 && fc0 == 3'd2) && n < 500) begin
      @(negedge clock);
      n++;
    end
    chk("t3_idle_seen", 32'(fa0), 0);
    in_data = wa[3];
    v0 = 1'b1;
    @(negedge clock);
    v0 = 1'b0;
    chk("t3_pushpop_count", 32'(fc0), 2);
    chk("t3_pushpop_active", 32'(fa0), 1);
    wait_fs0(8'd10, 3000, "t3_frames");
    for (int i = 0; i < 4; i++) add_frame(wa[i]);
    cmp_log0("t3_bytes");

    // Reset while waiting for the second byte's acknowledge
    q0.delete();
    wa = '{16'hB00C, 16'h0102, 16'h0304, 16'h0506};
    push_words0(wa, 4);
    chk("t4_queued", 32'(fc0), 3);
    n = 0;
    while (q0.size() < 1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    noack0 = 1'b1;
    chk("t4_first_byte", 32'(q0.size()), 1);
    n = 0;
    while (ts0 !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    repeat (2) @(negedge clock);
    chk("t4_wait_ack", 32'(ts0), 1);
    chk("t4_byte2", 32'(td0), 'h0C);
    reset = 1'b0;
    @(negedge clock);
    chk("t4_rst_start", 32'(ts0), 0);
    chk("t4_rst_data", 32'(td0), 0);
    chk("t4_rst_count", 32'(fc0), 0);
    chk("t4_rst_frames", 32'(fs0), 0);
    chk("t4_rst_active", 32'(fa0), 0);
    reset = 1'b1;
    noack0 = 1'b0;
    repeat (60) @(negedge clock);
    chk("t4_no_more_bytes", 32'(q0.size()), 1);
    chk("t4_frames_after", 32'(fs0), 0);
    chk("t4_idle_after", 32'(fa0), 0);

    // 256 frames with a fast UART to exercise counter wrap
    busy_len = 1;
    q0.delete();
    pushed = 0;
    n = 0;
    while (fs0 !== 8'd255 && n < 20000) begin
      in_data = 16'(pushed);
      v0 = (pushed < 255);
      rdy = r0;
      @(posedge clock);
      if (v0 && rdy) pushed++;
      @(negedge clock);
      n++;
    end
    v0 = 1'b0;
    chk("t5_255", 32'(fs0), 255);
    in_data = 16'h00FF;
    v0 = 1'b1;
    @(negedge clock);
    v0 = 1'b0;
    n = 0;
    while (fs0 === 8'd255 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("t5_wrap", 32'(fs0), 0);
    chk("t5_inactive", 32'(fa0), 0);
    chk("t5_bytes", 32'(q0.size()), 1024);
    chk("t5_last_sync", 32'(q0[1020]), 'hA5);
    chk("t5_last_lo", 32'(q0[1021]), 'hFF);
    chk("t5_last_hi", 32'(q0[1022]), 'h00);
    chk("t5_last_chk", 32'(q0[1023]), 'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_tx_sequencer.md
ALU_TX_SEQUENCER -- requirements
Module: alu_tx_sequencer

Interface
REQ-001 SHALL have parameter RESULT_W, default 16, result word width; multiple of 8, range 8..64.
REQ-002 SHALL have parameter DEPTH, default 4, result FIFO depth in words; power of 2, at least 2.
REQ-003 SHALL have parameter FRAMED, default 1; 1 = sync byte + data bytes + checksum byte, 0 = data bytes only.
REQ-004 SHALL have parameter MSB_FIRST, default 0; 0 = least-significant data byte sent first.
REQ-005 SHALL have parameter SYNC_BYTE, default 8'hA5, first byte of every frame when FRAMED=1.
REQ-006 SHALL use one clock; reset is synchronous and active-low.
REQ-007 clock  in  1  sole clock; all state updates on rising edge.
REQ-008 reset  in  1  synchronous, active-low reset.
REQ-009 in_data  in  RESULT_W  result word to transmit.
REQ-010 in_valid  in  1  in_data valid this cycle.
REQ-011 in_ready  out  1  FIFO can accept a word; push = in_valid & in_ready.
REQ-012 tx_start  out  1  byte request to the UART transmitter.
REQ-013 tx_data  out  8  byte to send; held stable while tx_start=1.
REQ-014 tx_busy  in  1  UART transmitter busy.
REQ-015 frame_active  out  1  high from word pop until last byte completes.
REQ-016 fifo_count  out  $clog2(DEPTH)+1  words stored in FIFO.
REQ-017 frames_sent  out  8  count of completed frames; wraps 255->0.

Function
REQ-018 FIFO SHALL be first-in first-out; in_ready = (fifo_count < DEPTH), combinational from count only.
REQ-019 Push and pop in the same cycle SHALL leave fifo_count unchanged and store/remove the correct words; when full, in_ready=0 even if a pop occurs that cycle.
REQ-020 Frame byte count N SHALL be RESULT_W/8 + 2*FRAMED; byte order: [SYNC_BYTE], data bytes per MSB_FIRST, [checksum].
REQ-021 Checksum SHALL be bitwise XOR of all data bytes of the frame, excluding SYNC_BYTE.
REQ-022 States: IDLE, START, WAIT_ACK, WAIT_DONE.
REQ-023 IDLE: if fifo_count>0, pop head word into a holding register, byte index=0, frame_active=1, go to START; else stay.
REQ-024 START: assert tx_start=1 with tx_data = byte[index]; go to WAIT_ACK (tx_start rises exactly one cycle after the pop edge).
REQ-025 WAIT_ACK: hold tx_start=1 and tx_data; on sampling tx_busy=1, drive tx_start=0 and go to WAIT_DONE; no timeout.
REQ-026 WAIT_DONE: on sampling tx_busy=0, if index=N-1 then frames_sent+1, frame_active=0, go to IDLE; else index+1, go to START.
REQ-027 tx_busy SHALL be ignored in IDLE and START.
REQ-028 Pushes SHALL be accepted in every state; the holding register SHALL be unaffected by FIFO activity.
REQ-029 tx_data SHALL be 8'h00 whenever tx_start=0 and in IDLE.

Reset
REQ-030 With reset=0 at a rising edge: state=IDLE, tx_start=0, tx_data=8'h00, frame_active=0, FIFO empty (fifo_count=0, in_ready=1), frames_sent=0, byte index=0.
REQ-031 Reset mid-frame SHALL abort the frame without sending remaining bytes, discard FIFO contents, and not increment frames_sent.
REQ-032 in_valid during reset SHALL NOT push.

Verification
REQ-033 RESULT_W=16, FRAMED=1, MSB_FIRST=0; push 16'h1234; UART model (busy 1 cycle after start, 10 cycles high) -> bytes A5,34,12,26; frames_sent=1; frame_active low after 4th busy fall.
REQ-034 Same with MSB_FIRST=1 -> A5,12,34,26; with FRAMED=0, MSB_FIRST=0 -> 34,12 only, no sync/checksum.
REQ-035 DEPTH=4, tx_busy held 1; push 6 words back-to-back -> word 1 popped, words 2-5 stored, fifo_count=4, in_ready=0, word 6 refused; release busy -> frames emitted in push order.
REQ-036 FIFO at count 2, simultaneous push and pop -> count stays 2; subsequent frames preserve order.
REQ-037 Reset asserted in WAIT_ACK of byte 2 with 3 words queued -> next edge tx_start=0, fifo_count=0, frames_sent=0, no further bytes.
REQ-038 Send 256 frames -> frames_sent wraps to 0 after the 256th.
